hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on the rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 id_rs, id_rt  in  5 each  source register addresses of the instruction in ID.
REQ-004 id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs / rt.
REQ-005 id_dest  in  5  destination register of the ID instruction (rd for R-type, rt for load/I-type).
REQ-006 id_reg_write, id_mem_load  in  1 each  ID instruction writes a register / is a load.
REQ-007 branch_taken  in  1  branch in EX resolved taken this cycle.
REQ-008 mem_busy  in  1  data memory not ready; the whole pipeline must freeze.
REQ-009 pipe_en  out  1  global enable for all pipeline registers.
REQ-010 stall_if_id  out  1  hold PC and IF/ID.
REQ-011 bubble_id_ex  out  1  load a NOP into ID/EX.
REQ-012 flush_if_id  out  1  clear IF/ID.
REQ-013 fwd_a_sel, fwd_b_sel  out  2 each  ALU operand source for EX rs / rt: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB write-back data.
REQ-014 stall_cnt  out  16  saturating count of load-use stall cycles.

Function
REQ-015 Scoreboard: three entries (EX, MEM, WB), each {valid, rs, rt, dest, reg_write, mem_load}; they shift EX->MEM->WB on every clk with pipe_en=1.
REQ-016 The EX entry loads the ID fields when pipe_en=1, unless bubble_id_ex=1, in which case it loads valid=0.
REQ-017 Load-use hazard: EX.valid & EX.mem_load & EX.dest!=0 & ((id_uses_rs & id_rs==EX.dest) | (id_uses_rt & id_rt==EX.dest)).
REQ-018 On a load-use hazard in state RUN: stall_if_id=1 and bubble_id_ex=1 in the same cycle (combinational); next state LU_STALL.
REQ-019 In LU_STALL, load-use detection is suppressed, so at most one stall is taken per consumer; next state RUN.
REQ-020 On branch_taken=1: flush_if_id=1 and bubble_id_ex=1; branch takes priority over load-use (stall_if_id=0, no LU_STALL entry).
REQ-021 On mem_busy=1 in any state: pipe_en=0, stall/bubble/flush=0, scoreboard and state held; FSM enters FREEZE.
REQ-022 In FREEZE, on mem_busy=0 the FSM returns to the state held before FREEZE; hazard evaluation resumes that cycle.
REQ-023 fwd_a_sel: 01 if MEM.valid & MEM.reg_write & MEM.dest!=0 & MEM.dest==EX.rs; else 10 if the same holds for WB; else 00. fwd_b_sel follows the same rule on EX.rt.
REQ-024 MEM has priority over WB when both match (youngest value wins).
REQ-025 Register 0 is never forwarded and never causes a stall.
REQ-026 A MEM entry with mem_load=1 matching an EX source is illegal; the stall of REQ-018 guarantees it never occurs, and a bench assertion checks it.
REQ-027 stall_cnt increments on each cycle with stall_if_id=1 and saturates at 16'hFFFF.

Reset
REQ-028 While rst=1: state RUN, all scoreboard valid=0, stall_cnt=0, pipe_en=0, and all other outputs 0 (fwd selects 00).
REQ-029 After rst deasserts: pipe_en=1 from the first cycle, unless mem_busy=1.
REQ-030 Reset asserted mid-stall or mid-freeze aborts the stall or freeze immediately with no residual bubble.

Structure
REQ-031 A shared package hazard_pkg holds the FSM state enum {RUN, LU_STALL, FREEZE}, the fwd select encodings FWD_RF=00, FWD_EXMEM=01, FWD_MEMWB=10, and the scoreboard entry struct.
REQ-032 Sub-module hazard_sb_stage implements one scoreboard entry register (enable, bubble-load, async reset) and is instantiated three times.
REQ-033 Target size: 150-300 lines of RTL.

Verification
REQ-034 lw $8 followed by add $9,$8,$10: one cycle with stall_if_id=1 and bubble_id_ex=1; two cycles later fwd_a_sel=10; stall_cnt=1.
REQ-035 add $3,$1,$2 followed by sub $4,$3,$3: no stall; fwd_a_sel=fwd_b_sel=01 for the sub in EX.
REQ-036 add $5 followed by add $5 followed by or $6,$5,$0: fwd_a_sel=01 (MEM beats WB); fwd_b_sel=00 for $0.
REQ-037 lw $7 in EX with a consumer of $7 in ID and branch_taken=1: flush_if_id=1, bubble_id_ex=1, stall_if_id=0, stall_cnt unchanged.
REQ-038 mem_busy=1 for 3 cycles during LU_STALL: pipe_en=0 for 3 cycles and fwd selects stable; then LU_STALL resumes and completes with no second stall.
REQ-039 rst pulsed mid-FREEZE: all outputs 0 during reset; first post-reset cycle has pipe_en=1, state RUN and stall_cnt=0.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Purpose  : Shared types for the pipeline hazard controller. Holds the
//             controller FSM state encoding, the forwarding mux select
//             encodings and the scoreboard entry layout, plus the helper that
//             picks a forwarding source for one EX operand.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      FREEZE   = 2'd2
   } state_t;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   // rs/rt hold 0 when the instruction does not read that operand, so an
   // unused field can never trigger a spurious forward.
   typedef struct packed {
      logic       valid;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] dest;
      logic       reg_write;
      logic       mem_load;
   } sb_entry_t;

   // Youngest producer wins: MEM is checked before WB. Register 0 is
   // hard-wired and is never a forwarding source.
   function automatic logic [1:0] fwd_select(input sb_entry_t mem_e,
                                             input sb_entry_t wb_e,
                                             input logic [4:0] src);
      logic [1:0] sel;
      sel = FWD_RF;
      if (mem_e.valid && mem_e.reg_write && (mem_e.dest != 5'd0) &&
          (mem_e.dest == src)) begin
         sel = FWD_EXMEM;
      end else if (wb_e.valid && wb_e.reg_write && (wb_e.dest != 5'd0) &&
                   (wb_e.dest == src)) begin
         sel = FWD_MEMWB;
      end
      return sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_sb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_sb_stage
//  Purpose  : One scoreboard entry register. Loads d_i when enabled, or an
//             empty entry when bubble_i is also set; cleared by async reset.
//  Ports    : clk, rst       - clock, asynchronous active-high reset
//             en_i           - pipeline advance enable
//             bubble_i       - load an empty (invalid) entry instead of d_i
//             d_i            - entry arriving from the previous stage
//             q_o            - current entry
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_sb_stage
   import hazard_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      en_i,
   input  logic      bubble_i,
   input  sb_entry_t d_i,
   output sb_entry_t q_o
);

   sb_entry_t entry_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry_q <= '0;
      end else if (en_i) begin
         entry_q <= bubble_i ? sb_entry_t'('0) : d_i;
      end
   end

   assign q_o = entry_q;

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_controller
//  Purpose  : Pipeline hazard unit. Tracks the EX/MEM/WB instructions in a
//             three-entry scoreboard, detects load-use hazards against the
//             ID instruction, handles taken-branch flushes and data-memory
//             freezes, and selects ALU operand forwarding sources.
//  Ports    : clk, rst                 - clock, asynchronous active-high reset
//             id_rs, id_rt             - ID source registers
//             id_uses_rs, id_uses_rt   - ID actually reads rs / rt
//             id_dest                  - ID destination register
//             id_reg_write, id_mem_load- ID writes a register / is a load
//             branch_taken             - EX branch resolved taken
//             mem_busy                 - data memory not ready (freeze)
//             pipe_en                  - global pipeline register enable
//             stall_if_id              - hold PC and IF/ID
//             bubble_id_ex             - load NOP into ID/EX
//             flush_if_id              - clear IF/ID
//             fwd_a_sel, fwd_b_sel     - EX rs / rt operand source
//             stall_cnt                - saturating load-use stall count
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_controller
   import hazard_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic [4:0]  id_dest,
   input  logic        id_reg_write,
   input  logic        id_mem_load,
   input  logic        branch_taken,
   input  logic        mem_busy,
   output logic        pipe_en,
   output logic        stall_if_id,
   output logic        bubble_id_ex,
   output logic        flush_if_id,
   output logic [1:0]  fwd_a_sel,
   output logic [1:0]  fwd_b_sel,
   output logic [15:0] stall_cnt
);

   state_t      state_q, state_d;
   state_t      ret_q, ret_d;        // state to resume after FREEZE
   logic [15:0] cnt_q, cnt_d;

   state_t      w_eff_state;
   logic        w_active;
   logic        w_lu_raw;
   sb_entry_t   w_id_entry;
   sb_entry_t   w_sb_d [3];
   sb_entry_t   w_sb_q [3];
   sb_entry_t   w_ex, w_mem, w_wb;

   // ------------------------------------------------------------------
   // Scoreboard: EX <- ID, MEM <- EX, WB <- MEM
   // ------------------------------------------------------------------
   always_comb begin
      w_id_entry           = '0;
      w_id_entry.valid     = 1'b1;
      w_id_entry.rs        = id_uses_rs ? id_rs : 5'd0;
      w_id_entry.rt        = id_uses_rt ? id_rt : 5'd0;
      w_id_entry.dest      = id_dest;
      w_id_entry.reg_write = id_reg_write;
      w_id_entry.mem_load  = id_mem_load;
   end

   assign w_sb_d[0] = w_id_entry;
   assign w_sb_d[1] = w_sb_q[0];
   assign w_sb_d[2] = w_sb_q[1];

   for (genvar i = 0; i < 3; i++) begin : g_sb
      hazard_sb_stage u_stage (
         .clk      (clk),
         .rst      (rst),
         .en_i     (pipe_en),
         .bubble_i ((i == 0) ? bubble_id_ex : 1'b0),
         .d_i      (w_sb_d[i]),
         .q_o      (w_sb_q[i])
      );
   end

   assign w_ex  = w_sb_q[0];
   assign w_mem = w_sb_q[1];
   assign w_wb  = w_sb_q[2];

   // ------------------------------------------------------------------
   // Hazard detection and pipeline control
   // ------------------------------------------------------------------
   // While frozen, hazards are evaluated as if in the pre-freeze state so
   // that the very cycle mem_busy drops behaves like that state.
   assign w_eff_state = (state_q == FREEZE) ? ret_q : state_q;

   // Gating with rst keeps every control output low during reset.
   assign w_active = ~rst & ~mem_busy;

   assign w_lu_raw = w_ex.valid && w_ex.mem_load && (w_ex.dest != 5'd0) &&
                     ((id_uses_rs && (id_rs == w_ex.dest)) ||
                      (id_uses_rt && (id_rt == w_ex.dest)));

   // A taken branch discards the ID consumer, so no stall is needed.
   assign stall_if_id  = w_active & (w_eff_state == RUN) & w_lu_raw & ~branch_taken;
   assign flush_if_id  = w_active & branch_taken;
   assign bubble_id_ex = stall_if_id | flush_if_id;
   assign pipe_en      = w_active;

   assign fwd_a_sel = fwd_select(w_mem, w_wb, w_ex.rs);
   assign fwd_b_sel = fwd_select(w_mem, w_wb, w_ex.rt);

   assign stall_cnt = cnt_q;

   // ------------------------------------------------------------------
   // FSM and stall counter
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      cnt_d   = cnt_q;
      if (stall_if_id && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
      if (mem_busy) begin
         state_d = FREEZE;
         if (state_q != FREEZE) begin
            ret_d = state_q;
         end
      end else begin
         case (w_eff_state)
            LU_STALL: state_d = RUN;
            default:  state_d = stall_if_id ? LU_STALL : RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         ret_q   <= RUN;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         cnt_q   <= cnt_d;
      end
   end

   // Scoreboard fields carried along for the pipeline but not consumed here.
   logic w_unused_bits;
   assign w_unused_bits = ^{w_ex.reg_write, w_mem.rs, w_mem.rt, w_mem.mem_load,
                            w_wb.rs, w_wb.rt, w_wb.mem_load};

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_controller
//  Purpose  : Directed-vector bench for hazard_controller. Each cycle's
//             stimulus pushes its hand-computed expected outputs into a queue;
//             a monitor on the falling edge pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;
   import hazard_pkg::*;

   logic        clk;
   logic        rst;
   logic [4:0]  id_rs, id_rt, id_dest;
   logic        id_uses_rs, id_uses_rt, id_reg_write, id_mem_load;
   logic        branch_taken, mem_busy;
   logic        pipe_en, stall_if_id, bubble_id_ex, flush_if_id;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic [15:0] stall_cnt;

   hazard_controller dut (
      .clk          (clk),
      .rst          (rst),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rs   (id_uses_rs),
      .id_uses_rt   (id_uses_rt),
      .id_dest      (id_dest),
      .id_reg_write (id_reg_write),
      .id_mem_load  (id_mem_load),
      .branch_taken (branch_taken),
      .mem_busy     (mem_busy),
      .pipe_en      (pipe_en),
      .stall_if_id  (stall_if_id),
      .bubble_id_ex (bubble_id_ex),
      .flush_if_id  (flush_if_id),
      .fwd_a_sel    (fwd_a_sel),
      .fwd_b_sel    (fwd_b_sel),
      .stall_cnt    (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] rs;
      logic       urs;
      logic [4:0] rt;
      logic       urt;
      logic [4:0] dst;
      logic       rw;
      logic       ld;
   } ins_t;

   typedef struct {
      int          cyc;
      logic        pe, st, bub, fl;
      logic [1:0]  fa, fb;
      logic [15:0] cnt;
      logic        chk_run;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc_no      = 0;

   function automatic ins_t NOP();
      ins_t x;
      x = '0;
      return x;
   endfunction

   function automatic ins_t LW(input logic [4:0] d, input logic [4:0] base);
      ins_t x;
      x = '0; x.rs = base; x.urs = 1'b1; x.dst = d; x.rw = 1'b1; x.ld = 1'b1;
      return x;
   endfunction

   function automatic ins_t ALU(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
      ins_t x;
      x = '0; x.rs = s; x.urs = 1'b1; x.rt = t; x.urt = 1'b1; x.dst = d; x.rw = 1'b1;
      return x;
   endfunction

   task automatic cyc(input logic r, input ins_t in, input logic br, input logic mb,
                      input logic e_pe, input logic e_st, input logic e_bub, input logic e_fl,
                      input logic [1:0] e_fa, input logic [1:0] e_fb,
                      input logic [15:0] e_cnt, input logic e_run);
      exp_t x;
      @(posedge clk); #1;
      rst          = r;
      id_rs        = in.rs;  id_uses_rs = in.urs;
      id_rt        = in.rt;  id_uses_rt = in.urt;
      id_dest      = in.dst; id_reg_write = in.rw; id_mem_load = in.ld;
      branch_taken = br;
      mem_busy     = mb;
      cyc_no++;
      x.cyc = cyc_no; x.pe = e_pe; x.st = e_st; x.bub = e_bub; x.fl = e_fl;
      x.fa = e_fa; x.fb = e_fb; x.cnt = e_cnt; x.chk_run = e_run;
      q.push_back(x);
   endtask

   task automatic chk(input string nm, input int c, input logic [15:0] act, input logic [15:0] exp);
      if (act !== exp) begin
         $display("FAIL cycle %0d %s: got %0h, expected %0h", c, nm, act, exp);
         miscompares++;
      end
   endtask

   // Monitor: compare the queued expectation for this cycle on the falling edge.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         e = q.pop_front();
         vectors++;
         chk("pipe_en",      e.cyc, 16'(pipe_en),      16'(e.pe));
         chk("stall_if_id",  e.cyc, 16'(stall_if_id),  16'(e.st));
         chk("bubble_id_ex", e.cyc, 16'(bubble_id_ex), 16'(e.bub));
         chk("flush_if_id",  e.cyc, 16'(flush_if_id),  16'(e.fl));
         chk("fwd_a_sel",    e.cyc, 16'(fwd_a_sel),    16'(e.fa));
         chk("fwd_b_sel",    e.cyc, 16'(fwd_b_sel),    16'(e.fb));
         chk("stall_cnt",    e.cyc, stall_cnt,         e.cnt);
         if (e.chk_run) chk("state", e.cyc, 16'(dut.state_q), 16'(RUN));
      end
      // A load in MEM must never be the producer of an EX source operand.
      if (!rst && dut.w_mem.valid && dut.w_mem.mem_load && (dut.w_mem.dest != 5'd0) &&
          ((dut.w_mem.dest == dut.w_ex.rs) || (dut.w_mem.dest == dut.w_ex.rt))) begin
         $display("FAIL cycle %0d load_in_mem_fwd: got dest %0d matching EX source, expected none",
                  cyc_no, dut.w_mem.dest);
         miscompares++;
      end
   end

   initial begin
      rst = 1'b1;
      id_rs = '0; id_rt = '0; id_dest = '0;
      id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_reg_write = 1'b0; id_mem_load = 1'b0;
      branch_taken = 1'b0; mem_busy = 1'b0;

      //  rst ins             br mb  pe st bu fl  fa     fb     cnt    run
      // Reset: everything low even with branch_taken asserted
      cyc(1, NOP(),           1, 0,  0, 0, 0, 0, 2'b00, 2'b00, 16'd0, 0);
      // lw $8 ; add $9,$8,$10 : one stall, then MEM/WB forward
      cyc(0, LW(8,29),        0, 0,  1, 0, 0, 0, 2'b00, 2'b00, 16'd0, 0);
      cyc(0, ALU(9,8,10),     0, 0,  1, 1, 1, 0, 2'b00, 2'b00, 16'd0, 0);
      cyc(0, ALU(9,8,10),     0, 0,  1, 0, 0, 0, 2'b00, 2'b00, 16'd1, 0);
      cyc(0, NOP(),           0, 0,  1, 0, 0, 0, 2'b10, 2'b00, 16'd1, 0);
      cyc(0, NOP(),           0, 0,  1, 0, 0, 0, 2'b00, 2'b00, 16'd1, 0);
      // add $3,$1,$2 ; sub $4,$3,$3 : both operands from EX/MEM
      cyc(0, ALU(3,1,2),      0, 0,  1, 0, 0, 0, 2'b00, 2'b00, 16'd1, 0);
      cyc(0, ALU(4,3,3),      0, 0,  1, 0, 0, 0, 2'b00, 2'b00, 16'd1, 0);
      cyc(0, NOP(),           0, 0,  1, 0, 0, 0, 2'b01, 2'b01, 16'd1, 0);
      // add $5 ; add $5 ; or $6,$5,$0 : MEM beats WB, $0 never forwarded
      cyc(0, ALU(5,1,2),      0, 0,  1, 0, 0, 0, 2'b00, 2'b00, 16'd1, 0);
      cyc(0, ALU(5,11,12),    0, 0,  1, 0, 0, 0, 2'b00, 2'b00, 16'd1, 0);
      cyc(0, ALU(6,5,0),      0, 0,  1, 0, 0, 0, 2'b00, 2'b00, 16'd1, 0);
      cyc(0, NOP(),           0, 0,  1, 0, 0, 0, 2'b01, 2'b00, 16'd1, 0);
      // lw $0 ; add $7,$0,$0 : no stall, no forward from register 0
      cyc(0, LW(0,29),        0, 0,  1, 0, 0, 0, 2'b00, 2'b00, 16'd1, 0);
      cyc(0, ALU(7,0,0),      0, 0,  1, 0, 0, 0, 2'b00, 2'b00, 16'd1, 0);
      cyc(0, NOP(),           0, 0,  1, 0, 0, 0, 2'b00, 2'b00, 16'd1, 0);
      // lw $7 in EX, consumer in ID, branch taken: flush wins, no stall
      cyc(0, LW(7,29),        0, 0,  1, 0, 0, 0, 2'b00, 2'b00, 16'd1, 0);
      cyc(0, ALU(1,7,7),      1, 0,  1, 0, 1, 1, 2'b00, 2'b00, 16'd1, 0);
      cyc(0, NOP(),           0, 0,  1, 0, 0, 0, 2'b00, 2'b00, 16'd1, 0);
      cyc(0, NOP(),           0, 0,  1, 0, 0, 0, 2'b00, 2'b00, 16'd1, 0);
      // Load-use stall, then mem_busy for 3 cycles during LU_STALL
      cyc(0, LW(8,29),        0, 0,  1, 0, 0, 0, 2'b00, 2'b00, 16'd1, 0);
      cyc(0, ALU(9,8,10),     0, 0,  1, 1, 1, 0, 2'b00, 2'b00, 16'd1, 0);
      cyc(0, ALU(9,8,10),     0, 1,  0, 0, 0, 0, 2'b00, 2'b00, 16'd2, 0);
      cyc(0, ALU(9,8,10),     0, 1,  0, 0, 0, 0, 2'b00, 2'b00, 16'd2, 0);
      cyc(0, ALU(9,8,10),     0, 1,  0, 0, 0, 0, 2'b00, 2'b00, 16'd2, 0);
      cyc(0, ALU(9,8,10),     0, 0,  1, 0, 0, 0, 2'b00, 2'b00, 16'd2, 0);
      cyc(0, NOP(),           0, 0,  1, 0, 0, 0, 2'b10, 2'b00, 16'd2, 0);
      // Reset pulsed mid-freeze
      cyc(0, NOP(),           0, 1,  0, 0, 0, 0, 2'b00, 2'b00, 16'd2, 0);
      cyc(1, NOP(),           1, 0,  0, 0, 0, 0, 2'b00, 2'b00, 16'd0, 0);
      cyc(0, NOP(),           0, 0,  1, 0, 0, 0, 2'b00, 2'b00, 16'd0, 1);
      // Freeze arriving on a load-use cycle defers the stall to the resume cycle
      cyc(0, LW(8,29),        0, 0,  1, 0, 0, 0, 2'b00, 2'b00, 16'd0, 0);
      cyc(0, ALU(9,8,10),     0, 1,  0, 0, 0, 0, 2'b00, 2'b00, 16'd0, 0);
      cyc(0, ALU(9,8,10),     0, 0,  1, 1, 1, 0, 2'b00, 2'b00, 16'd0, 0);
      cyc(0, ALU(9,8,10),     0, 0,  1, 0, 0, 0, 2'b00, 2'b00, 16'd1, 0);
      cyc(0, NOP(),           0, 0,  1, 0, 0, 0, 2'b10, 2'b00, 16'd1, 0);

      for (int k = 0; k < 5 && q.size() != 0; k++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
         miscompares++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
